// File: rtl/prf_busy_table_pkg.sv
// Shared defines for the physical-register busy table: register count,
// lookup/wake port counts and the physical register number type.
package prf_busy_table_pkg;

  localparam int PRF_NUM         = 64;
  localparam int PRF_NUM_W       = $clog2(PRF_NUM);
  localparam int BUSY_RD_PORTS   = 10;
  localparam int BUSY_WAKE_PORTS = 4;
  localparam int BUSY_CNT_W      = PRF_NUM_W + 1;

  typedef logic [PRF_NUM_W-1:0] PRFNum;

endpackage

// File: rtl/prf_busy_table_read.sv
// busy_read_port: one source-operand lookup into the busy table.
// Optional macro BUSY_WAKE_BYPASS_EN: a wake for the looked-up register in
// the same cycle forces the result to "not busy" (zero-latency wakeup).
module busy_read_port
  import prf_busy_table_pkg::*;
#(
  parameter int PRF_NUM    = prf_busy_table_pkg::PRF_NUM,
  parameter int WAKE_PORTS = BUSY_WAKE_PORTS
) (
  input  logic [PRF_NUM-1:0]                        busy_q,
  input  logic [$clog2(PRF_NUM)-1:0]                rd_num,
  input  logic [WAKE_PORTS-1:0]                     wake_en,
  input  logic [WAKE_PORTS-1:0][$clog2(PRF_NUM)-1:0] wake_num,
  output logic                                      busy_o
);

`ifdef BUSY_WAKE_BYPASS_EN
  // Table lookup, cancelled by any same-cycle wake of the same register
  always_comb begin
    busy_o = busy_q[rd_num];
    for (int j = 0; j < WAKE_PORTS; j++) begin
      if (wake_en[j] && (wake_num[j] == rd_num)) begin
        busy_o = 1'b0;
      end
    end
  end
`else
  // Without bypass the wake inputs only matter through the registered table
  logic unused_wake;
  assign unused_wake = ^{wake_en, wake_num};

  // Plain table lookup; a wake shows up once the table register updates
  always_comb begin
    busy_o = busy_q[rd_num];
  end
`endif

endmodule

// File: rtl/prf_busy_table.sv
// prf_busy_table: one busy bit per physical register, set on rename
// allocation and cleared on wakeup, with a registered popcount.
// Optional macro BUSY_WAKE_BYPASS_EN enables same-cycle wake bypass on reads.
module prf_busy_table
  import prf_busy_table_pkg::*;
#(
  parameter int PRF_NUM  = prf_busy_table_pkg::PRF_NUM,
  parameter int RD_PORTS = BUSY_RD_PORTS
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic                                          alloc_en_0,
  input  logic                                          alloc_en_1,
  input  logic [$clog2(PRF_NUM)-1:0]                    alloc_num_0,
  input  logic [$clog2(PRF_NUM)-1:0]                    alloc_num_1,
  input  logic [BUSY_WAKE_PORTS-1:0]                    wake_en,
  input  logic [BUSY_WAKE_PORTS-1:0][$clog2(PRF_NUM)-1:0] wake_num,
  input  logic [RD_PORTS-1:0][$clog2(PRF_NUM)-1:0]      rd_num_l,
  input  logic [RD_PORTS-1:0][$clog2(PRF_NUM)-1:0]      rd_num_r,
  output logic [RD_PORTS-1:0]                           busyvec_l,
  output logic [RD_PORTS-1:0]                           busyvec_r,
  output logic [$clog2(PRF_NUM):0]                      busy_cnt
);

  localparam int CW = $clog2(PRF_NUM) + 1;

  logic [PRF_NUM-1:0] busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      riseCnt, fallCnt;

  // Next table state: wakes clear, allocations set afterwards so they win,
  // flush wipes everything, and register 0 is pinned to not-busy
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < BUSY_WAKE_PORTS; j++) begin
      if (wake_en[j]) begin
        busy_d[wake_num[j]] = 1'b0;
      end
    end
    if (alloc_en_0 && (alloc_num_0 != '0)) begin
      busy_d[alloc_num_0] = 1'b1;
    end
    if (alloc_en_1 && (alloc_num_1 != '0)) begin
      busy_d[alloc_num_1] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Incremental count update from the 0->1 and 1->0 transitions of this cycle
  always_comb begin
    riseCnt = '0;
    fallCnt = '0;
    for (int i = 0; i < PRF_NUM; i++) begin
      riseCnt = riseCnt + {{(CW-1){1'b0}}, ( busy_d[i] & ~busy_q[i])};
      fallCnt = fallCnt + {{(CW-1){1'b0}}, (~busy_d[i] &  busy_q[i])};
    end
    cnt_d = cnt_q + riseCnt - fallCnt;
  end

  // Table and count registers; reset overrides every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // One lookup instance per source-operand port on each side
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    busy_read_port #(
      .PRF_NUM    (PRF_NUM),
      .WAKE_PORTS (BUSY_WAKE_PORTS)
    ) u_rd_l (
      .busy_q   (busy_q),
      .rd_num   (rd_num_l[p]),
      .wake_en  (wake_en),
      .wake_num (wake_num),
      .busy_o   (busyvec_l[p])
    );

    busy_read_port #(
      .PRF_NUM    (PRF_NUM),
      .WAKE_PORTS (BUSY_WAKE_PORTS)
    ) u_rd_r (
      .busy_q   (busy_q),
      .rd_num   (rd_num_r[p]),
      .wake_en  (wake_en),
      .wake_num (wake_num),
      .busy_o   (busyvec_r[p])
    );
  end

endmodule

// File: tb/tb_prf_busy_table.sv
// Directed and short pseudo-random checks of prf_busy_table.
module tb_prf_busy_table;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             alloc_en_0, alloc_en_1;
  logic [5:0]       alloc_num_0, alloc_num_1;
  logic [3:0]       wake_en;
  logic [3:0][5:0]  wake_num;
  logic [9:0][5:0]  rd_num_l, rd_num_r;
  logic [9:0]       busyvec_l, busyvec_r;
  logic [6:0]       busy_cnt;

  int testsRun  = 0;
  int testsFail = 0;

`ifdef BUSY_WAKE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  prf_busy_table dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_en_0  (alloc_en_0),
    .alloc_en_1  (alloc_en_1),
    .alloc_num_0 (alloc_num_0),
    .alloc_num_1 (alloc_num_1),
    .wake_en     (wake_en),
    .wake_num    (wake_num),
    .rd_num_l    (rd_num_l),
    .rd_num_r    (rd_num_r),
    .busyvec_l   (busyvec_l),
    .busyvec_r   (busyvec_r),
    .busy_cnt    (busy_cnt)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    flush       = 1'b0;
    alloc_en_0  = 1'b0;
    alloc_en_1  = 1'b0;
    alloc_num_0 = '0;
    alloc_num_1 = '0;
    wake_en     = '0;
    wake_num    = '0;
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checkCnt(input string name, input logic [6:0] exp);
    testsRun++;
    if (busy_cnt !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: busy_cnt got %0d expected %0d", name, busy_cnt, exp);
    end
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int p = 0; p < 10; p++) begin
      rd_num_l[p] = 6'(p);
      rd_num_r[p] = 6'(p);
    end
    #1;
    testsRun++;
    if (busyvec_l !== 10'b0 || busyvec_r !== 10'b0) begin
      testsFail++;
      $display("[TB] FAIL reset_read: l=%b r=%b expected all zero", busyvec_l, busyvec_r);
    end
    checkCnt("reset_cnt", 7'd0);
  endtask

  task automatic test_alloc_wake();
    // cycle t: allocate 5 and 17
    alloc_en_0 = 1'b1; alloc_num_0 = 6'd5;
    alloc_en_1 = 1'b1; alloc_num_1 = 6'd17;
    rd_num_l[0] = 6'd5;
    #1;
    checkBit("alloc_not_bypassed", busyvec_l[0], 1'b0);
    step();
    // t+1
    clearInputs();
    rd_num_l[1] = 6'd17;
    rd_num_l[2] = 6'd6;
    rd_num_r[9] = 6'd17;
    #1;
    checkBit("alloc_5_busy", busyvec_l[0], 1'b1);
    checkBit("alloc_17_busy", busyvec_l[1], 1'b1);
    checkBit("reg_6_idle", busyvec_l[2], 1'b0);
    checkBit("alloc_17_busy_r", busyvec_r[9], 1'b1);
    checkCnt("alloc_cnt", 7'd2);
    step();
    // t+2
    step();
    // t+3: wake 5 on the LSU port
    wake_en[2] = 1'b1; wake_num[2] = 6'd5;
    #1;
    checkBit("wake_same_cycle", busyvec_l[0], BYPASS ? 1'b0 : 1'b1);
    checkBit("wake_other_reg", busyvec_l[1], 1'b1);
    checkCnt("wake_cnt_before", 7'd2);
    step();
    // t+4
    clearInputs();
    #1;
    checkBit("wake_next_cycle", busyvec_l[0], 1'b0);
    checkCnt("wake_cnt_after", 7'd1);
  endtask

  task automatic test_collision();
    alloc_en_0 = 1'b1; alloc_num_0 = 6'd9;
    step();
    clearInputs();
    rd_num_l[3] = 6'd9;
    #1;
    checkBit("collision_pre", busyvec_l[3], 1'b1);
    checkCnt("collision_pre_cnt", 7'd2);
    alloc_en_1 = 1'b1; alloc_num_1 = 6'd9;
    wake_en[0] = 1'b1; wake_num[0] = 6'd9;
    step();
    clearInputs();
    #1;
    checkBit("collision_set_wins", busyvec_l[3], 1'b1);
    checkCnt("collision_cnt", 7'd2);
  endtask

  task automatic test_reg_zero();
    alloc_en_0 = 1'b1; alloc_num_0 = 6'd0;
    step();
    clearInputs();
    rd_num_l[4] = 6'd0;
    #1;
    checkBit("reg0_idle", busyvec_l[4], 1'b0);
    checkCnt("reg0_cnt", 7'd2);
  endtask

  task automatic test_duplicates();
    alloc_en_0 = 1'b1; alloc_num_0 = 6'd40;
    alloc_en_1 = 1'b1; alloc_num_1 = 6'd40;
    step();
    clearInputs();
    rd_num_r[0] = 6'd40;
    #1;
    checkBit("dup_alloc_busy", busyvec_r[0], 1'b1);
    checkCnt("dup_alloc_cnt", 7'd3);
    wake_en    = 4'b1011;
    wake_num[0] = 6'd40; wake_num[1] = 6'd40; wake_num[3] = 6'd40;
    step();
    clearInputs();
    #1;
    checkBit("dup_wake_idle", busyvec_r[0], 1'b0);
    checkCnt("dup_wake_cnt", 7'd2);
  endtask

  task automatic test_flush();
    // 17 and 9 are busy; add 20..29 for twelve in total
    for (int k = 0; k < 5; k++) begin
      alloc_en_0 = 1'b1; alloc_num_0 = 6'(20 + 2 * k);
      alloc_en_1 = 1'b1; alloc_num_1 = 6'(21 + 2 * k);
      step();
    end
    clearInputs();
    #1;
    checkCnt("flush_pre_cnt", 7'd12);
    flush = 1'b1;
    alloc_en_0 = 1'b1; alloc_num_0 = 6'd33;
    step();
    clearInputs();
    rd_num_l[0] = 6'd33; rd_num_l[1] = 6'd17; rd_num_l[2] = 6'd9;
    for (int p = 3; p < 10; p++) rd_num_l[p] = 6'(20 + p);
    for (int p = 0; p < 10; p++) rd_num_r[p] = 6'(20 + p);
    #1;
    testsRun++;
    if (busyvec_l !== 10'b0 || busyvec_r !== 10'b0) begin
      testsFail++;
      $display("[TB] FAIL flush_read: l=%b r=%b expected all zero", busyvec_l, busyvec_r);
    end
    checkCnt("flush_cnt", 7'd0);
  endtask

  task automatic test_reset_mid();
    alloc_en_0 = 1'b1; alloc_num_0 = 6'd3;
    alloc_en_1 = 1'b1; alloc_num_1 = 6'd4;
    step();
    rst = 1'b1;
    alloc_num_0 = 6'd7;
    wake_en[1] = 1'b1; wake_num[1] = 6'd3;
    step();
    rst = 1'b0;
    clearInputs();
    rd_num_l[0] = 6'd3; rd_num_l[1] = 6'd4; rd_num_l[2] = 6'd7;
    #1;
    testsRun++;
    if (busyvec_l[2:0] !== 3'b000) begin
      testsFail++;
      $display("[TB] FAIL reset_mid_read: got %b expected 000", busyvec_l[2:0]);
    end
    checkCnt("reset_mid_cnt", 7'd0);
  endtask

  task automatic test_random();
    logic [63:0] refBusy;
    logic [9:0]  expL, expR;
    int          expCnt;
    refBusy = '0;
    for (int c = 0; c < 1000; c++) begin
      clearInputs();
      alloc_en_0  = 1'($urandom_range(0, 1));
      alloc_en_1  = 1'($urandom_range(0, 1));
      alloc_num_0 = 6'($urandom_range(0, 15));
      alloc_num_1 = 6'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) begin
        wake_en[j]  = 1'($urandom_range(0, 1));
        wake_num[j] = 6'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < 10; p++) begin
        rd_num_l[p] = 6'($urandom_range(0, 15));
        rd_num_r[p] = 6'($urandom_range(0, 15));
      end
      #1;
      expCnt = 0;
      for (int i = 0; i < 64; i++) expCnt += int'(refBusy[i]);
      for (int p = 0; p < 10; p++) begin
        expL[p] = refBusy[rd_num_l[p]];
        expR[p] = refBusy[rd_num_r[p]];
        for (int j = 0; j < 4; j++) begin
          if (BYPASS && wake_en[j] && wake_num[j] == rd_num_l[p]) expL[p] = 1'b0;
          if (BYPASS && wake_en[j] && wake_num[j] == rd_num_r[p]) expR[p] = 1'b0;
        end
      end
      testsRun++;
      if (busyvec_l !== expL || busyvec_r !== expR) begin
        testsFail++;
        $display("[TB] FAIL random_read cycle %0d: l=%b r=%b expected l=%b r=%b",
                 c, busyvec_l, busyvec_r, expL, expR);
      end
      testsRun++;
      if (busy_cnt !== 7'(expCnt)) begin
        testsFail++;
        $display("[TB] FAIL random_cnt cycle %0d: got %0d expected %0d", c, busy_cnt, expCnt);
      end
      for (int j = 0; j < 4; j++) if (wake_en[j]) refBusy[wake_num[j]] = 1'b0;
      if (alloc_en_0 && alloc_num_0 != 0) refBusy[alloc_num_0] = 1'b1;
      if (alloc_en_1 && alloc_num_1 != 0) refBusy[alloc_num_1] = 1'b1;
      if (flush) refBusy = '0;
      step();
    end
    clearInputs();
  endtask

  initial begin
    rst = 1'b1;
    rd_num_l = '0;
    rd_num_r = '0;
    clearInputs();
    #2;
    test_reset();
    test_alloc_wake();
    test_collision();
    test_reg_zero();
    test_duplicates();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/prf_busy_table.md
PRF_BUSY_TABLE -- requirements
Module: prf_busy_table

Interface
REQ-001 Parameter PRF_NUM, default 64: number of physical registers; PRFNum width is $clog2(PRF_NUM) = 6.
REQ-002 Parameter RD_PORTS, default 10: read ports per side (8 queue slots plus 2 dispatch lanes).
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 flush  in  1  pipeline flush; synchronous, active-high.
REQ-006 alloc_en_0, alloc_en_1  in  1 each  rename lane allocates a destination.
REQ-007 alloc_num_0, alloc_num_1  in  PRFNum each  newly allocated destination register.
REQ-008 wake_en[3:0]  in  4  wake valid; [0..1] ALU, [2] LSU, [3] MDU.
REQ-009 wake_num[3:0]  in  4 x PRFNum  woken destination registers.
REQ-010 rd_num_l, rd_num_r  in  RD_PORTS x PRFNum each  source-operand lookups from the issue queue.
REQ-011 busyvec_l, busyvec_r  out  RD_PORTS each  busy bit per lookup.
REQ-012 busy_cnt  out  $clog2(PRF_NUM)+1 = 7  number of currently busy registers.

Function
REQ-013 State: busy_q[PRF_NUM-1:0], one bit per physical register.
REQ-014 Allocation: alloc_en_k sets busy_q[alloc_num_k]; the new value is visible in the following cycle.
REQ-015 Wake: wake_en_j clears busy_q[wake_num_j]; the new value is visible in the following cycle.
REQ-016 If set and clear target the same register in the same cycle, the set wins and the bit is 1 next cycle.
REQ-017 Duplicate wakes or duplicate allocations to one register in one cycle are legal and idempotent.
REQ-018 Register 0 is never busy: sets to number 0 are ignored, and busy_q[0] reads as 0.
REQ-019 Read: busyvec_x[p] = busy_q[rd_num_x[p]], combinational, with bypass as defined in REQ-025/026.
REQ-020 busy_cnt tracks popcount(busy_q) as a registered value.
  - Updated incrementally each cycle by the number of 0->1 and 1->0 transitions.
  - Always equals popcount(busy_q) after the edge.
REQ-021 flush clears every busy bit and busy_cnt to 0 next cycle; it overrides allocation and wake in the same cycle.

Reset
REQ-022 rst overrides flush and all other inputs.
REQ-023 After rst: busy_q = 0, busy_cnt = 0, and every busyvec output reads 0.
REQ-024 rst asserted mid-operation discards all pending sets and clears same cycle.

Configuration
REQ-025 With BUSY_WAKE_BYPASS_EN defined: busyvec_x[p] is additionally forced to 0 when any wake_en_j has wake_num_j == rd_num_x[p] in the same cycle (zero-latency wakeup).
REQ-026 Without BUSY_WAKE_BYPASS_EN: busyvec reflects busy_q only, so a wake becomes visible one cycle later.
REQ-027 Allocation is never bypassed to reads in either configuration.

Structure
REQ-028 PRFNum typedef, PRF_NUM, BUSY_RD_PORTS and BUSY_WAKE_PORTS belong in the shared defines package.
REQ-029 The lookup is one sub-module, busy_read_port, instantiated 2 x RD_PORTS times.
  - Inputs: busy_q, rd_num, wake_en, wake_num.
  - Output: one busy bit.
  - Contains the bypass compare under the macro.
REQ-030 Target size: 120-400 lines of RTL in total.

Verification
REQ-031 Reset then read: rst for 2 cycles, then rd_num_l[0..9] = 0..9 -> busyvec_l = 10'b0, busy_cnt = 0.
REQ-032 Allocate and wake: alloc 5 and 17 in cycle t -> at t+1, ports reading 5 and 17 return 1 and busy_cnt = 2. Wake 5 at t+3 -> with the macro, port reading 5 returns 0 in t+3; without it, returns 0 from t+4. busy_cnt = 1 from t+4.
REQ-033 Set/clear collision: busy_q[9] = 1, then in one cycle alloc 9 and wake 9 -> busy_q[9] = 1 and busy_cnt unchanged.
REQ-034 Register 0: alloc_num_0 = 0 with alloc_en_0 = 1 -> port reading 0 returns 0 and busy_cnt unchanged.
REQ-035 Flush with concurrent alloc: 12 registers busy, then flush together with alloc 33 -> next cycle all reads return 0 and busy_cnt = 0.
REQ-036 Randomized set/wake stream over 1000 cycles against a reference bit-array model -> zero busyvec or busy_cnt mismatches.
